// File: rtl/debounce_edge_detect_edge_detector.sv
`default_nettype none
// ============================================================================
//  Module   : edge_detector
//  Purpose  : Per-bit rising-edge pulse generator (delayed copy AND-NOT).
//  Revision : 1.0 - initial release
// ============================================================================
module edge_detector #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_level,
    output logic [WIDTH-1:0] o_pulse
);

    logic [WIDTH-1:0] r_level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level_q <= '0;
        end else begin
            r_level_q <= i_level;
        end
    end

    // i_level must itself be registered state for this to be glitch-free.
    assign o_pulse = i_level & ~r_level_q;

endmodule
`default_nettype wire

// File: rtl/debounce_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_edge_detect
//  Purpose  : Tick-sampled saturating debouncer with rising-edge pulse output.
//  Revision : 1.0 - initial release
// ============================================================================
module debounce_edge_detect #(
    parameter int WIDTH          = 1,
    parameter int SAMPLE_CNT_MAX = 62500,
    parameter int PULSE_CNT_MAX  = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] glitchy_signal,
    output logic [WIDTH-1:0] debounced_signal,
    output logic [WIDTH-1:0] edge_pulse
);

    localparam int c_tick_w = $clog2(SAMPLE_CNT_MAX);
    localparam int c_cnt_w  = $clog2(PULSE_CNT_MAX + 1);

    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(SAMPLE_CNT_MAX - 1);
    localparam logic [c_tick_w-1:0] c_tick_one  = c_tick_w'(1);
    localparam logic [c_cnt_w-1:0]  c_cnt_max   = c_cnt_w'(PULSE_CNT_MAX);
    localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);

    logic [c_tick_w-1:0] r_tick_cnt;
    logic                w_sample_tick;
    logic [WIDTH-1:0]    w_debounced;

    assign w_sample_tick = (r_tick_cnt == c_tick_last);

    // Free-running sample period shared by every bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_sample_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_tick_one;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [c_cnt_w-1:0] r_cnt;

        // A low level clears immediately; only the assert path is filtered.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (!glitchy_signal[i]) begin
                r_cnt <= '0;
            end else if (w_sample_tick && (r_cnt < c_cnt_max)) begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end

        assign w_debounced[i] = (r_cnt == c_cnt_max);
    end

    assign debounced_signal = w_debounced;

    edge_detector #(
        .WIDTH (WIDTH)
    ) u_edge_detector (
        .clk     (clk),
        .rst     (rst),
        .i_level (w_debounced),
        .o_pulse (edge_pulse)
    );

endmodule
`default_nettype wire

// File: tb/tb_debounce_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_debounce_edge_detect
//  Purpose  : Self-checking bench for debounce_edge_detect (W=2, S=4, P=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_edge_detect;

    localparam int c_width = 2;
    localparam int c_scm   = 4;
    localparam int c_pcm   = 3;

    typedef struct {
        logic [1:0] deb;
        logic [1:0] pulse;
    } exp_t;

    typedef struct {
        logic [1:0] in;
        logic [1:0] deb;
        logic [1:0] pulse;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] glitchy = 2'b00;
    logic [1:0] debounced;
    logic [1:0] edge_pulse;

    exp_t sb[$];
    vec_t tab[16];

    int n_checks = 0;
    int n_pass   = 0;
    int pulses0  = 0;

    int m_edge = 0;
    int m_run[2];
    logic [1:0] m_prev = 2'b00;

    debounce_edge_detect #(
        .WIDTH          (c_width),
        .SAMPLE_CNT_MAX (c_scm),
        .PULSE_CNT_MAX  (c_pcm)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .glitchy_signal   (glitchy),
        .debounced_signal (debounced),
        .edge_pulse       (edge_pulse)
    );

    always #5 clk = ~clk;

    // Reference: counts tick edges since the input was last low (unbounded).
    task automatic model_step(input logic [1:0] in, output exp_t e);
        bit tick;
        m_edge++;
        tick = (m_edge % c_scm) == 0;
        for (int b = 0; b < 2; b++) begin
            if (!in[b]) m_run[b] = 0;
            else if (tick) m_run[b]++;
            e.deb[b]   = (m_run[b] >= c_pcm);
            e.pulse[b] = e.deb[b] & ~m_prev[b];
            m_prev[b]  = e.deb[b];
        end
    endtask

    task automatic check(input string name, input exp_t e);
        n_checks++;
        if ({debounced, edge_pulse} !== {e.deb, e.pulse})
            $display("FAIL %s @%0t: deb=%b pulse=%b, required deb=%b pulse=%b",
                     name, $time, debounced, edge_pulse, e.deb, e.pulse);
        else
            n_pass++;
    endtask

    // Drive one cycle, push the prediction, pop and compare after the edge.
    task automatic cycle(input logic [1:0] in, input bit use_tab, input exp_t tab_e);
        exp_t e;
        exp_t got;
        glitchy = in;
        model_step(in, e);
        sb.push_back(use_tab ? tab_e : e);
        @(posedge clk);
        #1;
        if (edge_pulse[0]) pulses0++;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_empty @%0t: size=0, required 1", $time);
        end else begin
            got = sb.pop_front();
            check("cycle", got);
        end
    endtask

    task automatic run(input logic [1:0] in, input int n);
        exp_t dummy;
        dummy = '{2'b00, 2'b00};
        for (int k = 0; k < n; k++) cycle(in, 1'b0, dummy);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic do_reset(input logic [1:0] in);
        exp_t zero;
        zero = '{2'b00, 2'b00};
        glitchy = in;
        #2;
        rst = 1'b1;
        #1;
        check("reset_async", zero);
        @(posedge clk);
        #1;
        check("reset_held", zero);
        rst = 1'b0;
        m_edge = 0;
        m_run[0] = 0;
        m_run[1] = 0;
        m_prev = 2'b00;
    endtask

    initial begin
        exp_t e;
        for (int k = 0; k < 16; k++) begin
            tab[k].in    = 2'b01;
            tab[k].deb   = (k + 1 >= 12) ? 2'b01 : 2'b00;
            tab[k].pulse = (k + 1 == 12) ? 2'b01 : 2'b00;
        end

        @(posedge clk);
        #1;
        do_reset(2'b01);

        // Clean press: ticks at edges 4, 8, 12; rise and pulse at edge 12.
        for (int k = 0; k < 16; k++) begin
            e.deb   = tab[k].deb;
            e.pulse = tab[k].pulse;
            cycle(tab[k].in, 1'b1, e);
        end

        // Release drops one edge later, then an off-tick glitch during re-press.
        run(2'b00, 3);
        run(2'b01, 6);
        run(2'b00, 1);
        run(2'b01, 20);

        // Glitch coincident with the tick at edge 8: clear wins, rise at edge 20.
        do_reset(2'b01);
        run(2'b01, 7);
        run(2'b00, 1);
        run(2'b01, 16);

        // Long hold: saturates, exactly one pulse.
        do_reset(2'b01);
        pulses0 = 0;
        run(2'b01, 200);
        n_checks++;
        if (pulses0 != 1)
            $display("FAIL hold_pulse_count: got %0d pulses, required 1", pulses0);
        else
            n_pass++;

        // Reset while debounced high, then re-qualify with exactly one pulse.
        do_reset(2'b01);
        pulses0 = 0;
        run(2'b01, 20);
        n_checks++;
        if (pulses0 != 1)
            $display("FAIL requalify_pulse_count: got %0d pulses, required 1", pulses0);
        else
            n_pass++;

        // Independence: staggered presses, then a simultaneous press.
        do_reset(2'b01);
        run(2'b01, 5);
        run(2'b11, 16);
        run(2'b00, 2);
        run(2'b11, 14);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
